// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared types and lane helpers for the data-memory access controller
//
// Purpose: load/store size encodings, controller FSM state type, and the
//          byte-enable / write-data lane replication helpers shared by the
//          controller and anything else that needs to place data on lanes.
// Ports:   none (package).
package dm_pkg;

  typedef enum logic [1:0] {
    LS_NONE = 2'b00,
    LS_WORD = 2'b01,
    LS_HALF = 2'b10,
    LS_BYTE = 2'b11
  } ls_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PIPE_BUSY,
    ST_LDR_BUSY,
    ST_RESP
  } state_e;

  function automatic logic [3:0] lane_be(input ls_e ls, input logic [1:0] lo);
    logic [3:0] be;
    case (ls)
      LS_WORD: be = 4'b1111;
      LS_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      LS_BYTE: be = 4'b0001 << lo;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Store data arrives right-aligned; replicate it so whichever lane the
  // byte enables select already carries the right bits.
  function automatic logic [31:0] lane_wdata(input ls_e ls, input logic [31:0] wd);
    logic [31:0] r;
    case (ls)
      LS_HALF: r = {2{wd[15:0]}};
      LS_BYTE: r = {4{wd[7:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic is_misaligned(input ls_e ls, input logic [1:0] lo);
    return ((ls == LS_WORD) && (lo != 2'b00)) || ((ls == LS_HALF) && lo[0]);
  endfunction

endpackage

// File: rtl/dm_access_ctrl_if.sv
// rtl/dm_access_ctrl_if.sv - req/ack data-memory bus between controller and memory
//
// Purpose: groups the single-ported data-memory handshake.
// Signals: req, we, be[3:0], addr[ADDR_W-3:0] (word address), wdata[31:0]
//          driven by the controller; ack, rdata[31:0] driven by the memory.
// Modports: master (controller side), slave (memory side).
interface dm_access_ctrl_if #(
  parameter int ADDR_W = 13
);
  logic              req;
  logic              we;
  logic [3:0]        be;
  logic [ADDR_W-3:0] addr;
  logic [31:0]       wdata;
  logic              ack;
  logic [31:0]       rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/dm_load_fmt.sv
// rtl/dm_load_fmt.sv - load data lane select and sign/zero extension
//
// Purpose: picks the addressed halfword or byte out of a memory word and
//          extends it to 32 bits. Purely combinational so forwarding logic
//          can reuse it.
// Ports:   rdata[31:0] raw memory word, size (ls_e), addr_lo[1:0] byte
//          offset, ext (1 = sign-extend), data[31:0] formatted result.
module dm_load_fmt
  import dm_pkg::*;
(
  input  logic [31:0] rdata,
  input  ls_e         size,
  input  logic [1:0]  addr_lo,
  input  logic        ext,
  output logic [31:0] data
);

  logic [15:0] hsel;
  logic [7:0]  bsel;

  always_comb begin
    hsel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (addr_lo)
      2'd0:    bsel = rdata[7:0];
      2'd1:    bsel = rdata[15:8];
      2'd2:    bsel = rdata[23:16];
      default: bsel = rdata[31:24];
    endcase
    case (size)
      LS_HALF: data = {{16{ext & hsel[15]}}, hsel};
      LS_BYTE: data = {{24{ext & bsel[7]}}, bsel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// rtl/dm_access_ctrl.sv - MEM-stage data-memory sequencer and pipeline/loader arbiter
//
// Purpose: shares one single-ported data memory between the pipeline
//          (byte/half/word loads and stores) and the loader/debug port
//          (word only), stalling the pipeline until each access completes.
// Ports:   clock, reset (async, active-high)
//          p_ls/p_we/p_ext/p_addr/p_wdata  pipeline request
//          p_stall/p_done/p_rdata/p_misalign pipeline response
//          l_req/l_we/l_addr/l_wdata         loader request
//          l_ack/l_rdata                     loader response
//          mem                               memory bus (master side)
module dm_access_ctrl
  import dm_pkg::*;
#(
  parameter int ADDR_W     = 13,
  parameter int MAX_STREAK = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  p_ls,
  input  logic        p_we,
  input  logic        p_ext,
  input  logic [31:0] p_addr,
  input  logic [31:0] p_wdata,
  output logic        p_stall,
  output logic        p_done,
  output logic [31:0] p_rdata,
  output logic        p_misalign,
  input  logic        l_req,
  input  logic        l_we,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  output logic        l_ack,
  output logic [31:0] l_rdata,
  dm_access_ctrl_if.master mem
);

  localparam int SW = $clog2(MAX_STREAK + 1);

  state_e            state;
  logic [SW-1:0]     streak;
  logic              req_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [ADDR_W-3:0] addr_q;
  logic [31:0]       wdata_q;
  ls_e               fmt_ls;
  logic [1:0]        fmt_lo;
  logic              fmt_ext;
  logic [31:0]       fmt_data;

  ls_e  ls;
  logic ldr_win;

  assign ls = ls_e'(p_ls);
  // The loader only pre-empts a waiting pipeline once the pipeline has had
  // MAX_STREAK consecutive grants while the loader was asking.
  assign ldr_win = l_req && ((ls == LS_NONE) || (streak == SW'(MAX_STREAK)));

  assign p_stall = (ls != LS_NONE) && !p_done;

  assign mem.req   = req_q;
  assign mem.we    = we_q;
  assign mem.be    = be_q;
  assign mem.addr  = addr_q;
  assign mem.wdata = wdata_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{p_addr[31:ADDR_W], l_addr[31:ADDR_W], l_addr[1:0]};

  dm_load_fmt u_load_fmt (
    .rdata   (mem.rdata),
    .size    (fmt_ls),
    .addr_lo (fmt_lo),
    .ext     (fmt_ext),
    .data    (fmt_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      streak     <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= 4'b0000;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      fmt_ls     <= LS_NONE;
      fmt_lo     <= 2'b00;
      fmt_ext    <= 1'b0;
      p_done     <= 1'b0;
      p_rdata    <= 32'h0;
      p_misalign <= 1'b0;
      l_ack      <= 1'b0;
      l_rdata    <= 32'h0;
    end else begin
      p_done     <= 1'b0;
      p_misalign <= 1'b0;
      l_ack      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ldr_win) begin
            streak  <= '0;
            req_q   <= 1'b1;
            we_q    <= l_we;
            be_q    <= 4'b1111;
            addr_q  <= l_addr[ADDR_W-1:2];
            wdata_q <= l_wdata;
            state   <= ST_LDR_BUSY;
          end else if (ls != LS_NONE) begin
            if (!l_req)
              streak <= '0;
            else if (streak != SW'(MAX_STREAK))
              streak <= streak + 1'b1;
            if (is_misaligned(ls, p_addr[1:0])) begin
              // Misaligned accesses never reach memory; report and return.
              p_rdata    <= 32'h0;
              p_misalign <= 1'b1;
              p_done     <= 1'b1;
              state      <= ST_RESP;
            end else begin
              req_q   <= 1'b1;
              we_q    <= p_we;
              be_q    <= lane_be(ls, p_addr[1:0]);
              addr_q  <= p_addr[ADDR_W-1:2];
              wdata_q <= lane_wdata(ls, p_wdata);
              fmt_ls  <= ls;
              fmt_lo  <= p_addr[1:0];
              fmt_ext <= p_ext;
              state   <= ST_PIPE_BUSY;
            end
          end
        end
        ST_PIPE_BUSY: begin
          if (mem.ack) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            p_rdata <= we_q ? 32'h0 : fmt_data;
            p_done  <= 1'b1;
            state   <= ST_RESP;
          end
        end
        ST_LDR_BUSY: begin
          if (mem.ack) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            l_rdata <= mem.rdata;
            l_ack   <= 1'b1;
            state   <= ST_RESP;
          end
        end
        default: begin
          // One idle gap per access: anything pending waits for IDLE.
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
